sys_bus_bridge: RTL

- Parametrised, sequential successor to the combinational CPU-to-device address bridge.
- Decodes one CPU data-port access onto N_DEV memory-mapped devices using per-device base/mask windows.
- Runs a request/acknowledge handshake with per-access timeout, registers read data, and flags unmapped, illegal or timed-out accesses.
- Registers device interrupt lines onto the CPU's HWINT[7:2] vector. Sits between the CPU data-memory port and the timers/peripherals.

---
 rtl/bridge_pkg.sv | 26 ++
 rtl/sys_bus_bridge_if.sv | 40 ++++
 rtl/bridge_decoder.sv | 32 +++
 rtl/sys_bus_bridge.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and default memory map for the CPU-to-device bridges.
// Holds the FSM encoding, device windows, HWINT width and the index-width helper.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DM_BASE     = 32'h0000_0000;
  localparam logic [31:0] DM_MASK     = 32'hFFFF_C000;
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER0_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TIMER1_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] PERIPH_BASE = 32'h0000_7F20;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FFF0;

  localparam int HWINT_W = 6;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_bus_bridge_if.sv
// CPU data-port and device-side signals of the bridge.
// slave = bridge view, master = CPU/device-model view.
interface sys_bus_bridge_if #(
  parameter int N_DEV = 4
);
  import bridge_pkg::*;

  logic                        cpu_req;
  logic [31:0]                 cpu_addr;
  logic [31:0]                 cpu_wdata;
  logic                        cpu_we;
  logic [3:0]                  cpu_be;
  logic                        cpu_ready;
  logic [31:0]                 cpu_rdata;
  logic                        cpu_err;
  logic [N_DEV-1:0]            dev_sel;
  logic [29:0]                 dev_addr;
  logic [31:0]                 dev_wdata;
  logic                        dev_we;
  logic [3:0]                  dev_be;
  logic [N_DEV-1:0]            dev_ack;
  logic [32*N_DEV-1:0]         dev_rdata;
  logic [N_DEV-1:0]            dev_irq;
  logic [HWINT_W-1:0]          hwint;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_be,
    input  dev_ack, dev_rdata, dev_irq,
    output cpu_ready, cpu_rdata, cpu_err,
    output dev_sel, dev_addr, dev_wdata, dev_we, dev_be, hwint
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we, cpu_be,
    output dev_ack, dev_rdata, dev_irq,
    input  cpu_ready, cpu_rdata, cpu_err,
    input  dev_sel, dev_addr, dev_wdata, dev_we, dev_be, hwint
  );

endinterface

// File: rtl/bridge_decoder.sv
// Combinational base/mask address decoder: one-hot hit, index and any-hit.
// Overlapping windows resolve to the lowest channel index.
module bridge_decoder
  import bridge_pkg::*;
#(
  parameter int                  N_DEV    = 4,
  parameter logic [32*N_DEV-1:0] DEV_BASE = {PERIPH_BASE, TIMER1_BASE, TIMER0_BASE, DM_BASE},
  parameter logic [32*N_DEV-1:0] DEV_MASK = {PERIPH_MASK, TIMER1_MASK, TIMER0_MASK, DM_MASK},
  localparam int                 IDX_W    = idx_width(N_DEV)
) (
  input  logic [31:0]      i_addr,
  output logic [N_DEV-1:0] o_hit,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan downward so the last (lowest) matching channel overrides.
  always_comb begin
    o_hit = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if ((i_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_idx    = IDX_W'(i);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bus_bridge.sv
// Sequential CPU-to-device bridge: decode, req/ack with timeout, one-cycle cpu_ready pulse.
// Zero-wait access completes in 2 cycles, decode/size errors in 1; hwint is dev_irq delayed by one cycle.
module sys_bus_bridge
  import bridge_pkg::*;
#(
  parameter int                  N_DEV     = 4,
  parameter logic [32*N_DEV-1:0] DEV_BASE  = {PERIPH_BASE, TIMER1_BASE, TIMER0_BASE, DM_BASE},
  parameter logic [32*N_DEV-1:0] DEV_MASK  = {PERIPH_MASK, TIMER1_MASK, TIMER0_MASK, DM_MASK},
  parameter logic [N_DEV-1:0]    WORD_ONLY = 4'b1110,
  parameter int                  TIMEOUT   = 15
) (
  input logic                clk,
  input logic                reset,
  sys_bus_bridge_if.slave    bus
);

  localparam int                 IDX_W  = idx_width(N_DEV);
  localparam int                 CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   TO_CNT = CNT_W'(TIMEOUT);

  state_t              r_state;
  logic [IDX_W-1:0]    r_ch;
  logic [N_DEV-1:0]    r_sel;
  logic [29:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [3:0]          r_be;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [HWINT_W-1:0]  r_hwint;

  logic [N_DEV-1:0]    w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_size_bad;
  logic [31:0]         w_ack_data;
  logic [HWINT_W-1:0]  w_irq_ext;

  bridge_decoder #(
    .N_DEV    (N_DEV),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_dec (
    .i_addr (bus.cpu_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_size_bad = bus.cpu_we && WORD_ONLY[w_idx] && (bus.cpu_be != 4'b1111);
  assign w_ack_data = bus.dev_rdata[32*int'(r_ch) +: 32];

  always_comb begin
    w_irq_ext               = '0;
    w_irq_ext[N_DEV-1:0]    = bus.dev_irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            r_addr  <= bus.cpu_addr[31:2];
            r_wdata <= bus.cpu_wdata;
            r_we    <= bus.cpu_we;
            r_be    <= bus.cpu_be;
            r_ch    <= w_idx;
            r_cnt   <= '0;
            if (!w_any || w_size_bad) begin
              r_state <= ST_RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state <= ST_ACCESS;
              r_sel   <= w_hit;
            end
          end
        end
        ST_ACCESS: begin
          // Only the latched channel's ack counts; the counter is tested before it advances.
          if (bus.dev_ack[r_ch]) begin
            r_state <= ST_RESP;
            r_sel   <= '0;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : w_ack_data;
          end else if (r_cnt == TO_CNT) begin
            r_state <= ST_RESP;
            r_sel   <= '0;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_hwint <= '0;
    else       r_hwint <= w_irq_ext;
  end

  assign bus.cpu_ready = r_ready;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_err   = r_err;
  assign bus.dev_sel   = r_sel;
  assign bus.dev_addr  = r_addr;
  assign bus.dev_wdata = r_wdata;
  assign bus.dev_we    = r_we;
  assign bus.dev_be    = r_be;
  assign bus.hwint     = r_hwint;

endmodule
